// File: rtl/freq_meter.sv
// freq_meter
// Measures a square-wave input against the system clock. A start request arms
// the meter. The first synchronized rising edge of sig_in (the arming edge)
// opens a gate window of GATE_CNT clk cycles. During the window the meter
// counts sig_in rising edges and captures the length of the most recent full
// sig_in period. If no arming edge arrives within TIMEOUT_CNT cycles, the
// measurement ends with timeout set.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   start      : one-cycle request to begin a measurement (IDLE only)
//   sig_in     : measured input, asynchronous to clk
//   busy       : high from the cycle after an accepted start through DONE
//   done       : one-cycle pulse; results valid from this cycle
//   edge_count : rising edges counted inside the gate window
//   period     : clk cycles of the last complete sig_in period in the window
//   timeout    : no arming edge arrived within TIMEOUT_CNT cycles
module freq_meter #(
  parameter logic [15:0] GATE_CNT    = 16'd50000,
  parameter logic [15:0] TIMEOUT_CNT = 16'd60000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sig_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] edge_count,
  output logic [15:0] period,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_GATE = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic        sync1_r, sync2_r, sync3_r;
  logic        rise_s;
  logic [15:0] tcnt_r, gcnt_r, ecnt_r, pcnt_r, pcap_r;
  logic [15:0] ecnt_nxt_s, pcap_nxt_s, pcnt_sat_s;
  logic        busy_r, done_r, timeout_r;
  logic [15:0] edge_count_r, period_r;

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign rise_s = sync2_r & ~sync3_r;

  // Values including this cycle's edge, so a rise in the last gate cycle
  // still reaches the latched results.
  assign ecnt_nxt_s = rise_s ? (ecnt_r + 16'd1) : ecnt_r;
  assign pcap_nxt_s = rise_s ? pcnt_r : pcap_r;
  assign pcnt_sat_s = (pcnt_r == 16'hFFFF) ? 16'hFFFF : (pcnt_r + 16'd1);

  // Measurement FSM with counters and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      tcnt_r       <= 16'd0;
      gcnt_r       <= 16'd0;
      ecnt_r       <= 16'd0;
      pcnt_r       <= 16'd0;
      pcap_r       <= 16'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
      edge_count_r <= 16'd0;
      period_r     <= 16'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          tcnt_r <= 16'd0;
          gcnt_r <= 16'd0;
          ecnt_r <= 16'd0;
          pcnt_r <= 16'd0;
          pcap_r <= 16'd0;
          done_r <= 1'b0;
          if (start) begin
            state_r <= S_ARM;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        S_ARM: begin
          tcnt_r <= tcnt_r + 16'd1;
          if (rise_s) begin
            // The arming edge starts the window but is not counted.
            state_r <= S_GATE;
            gcnt_r  <= 16'd0;
            ecnt_r  <= 16'd0;
            pcnt_r  <= 16'd1;
            pcap_r  <= 16'd0;
          end else if (tcnt_r == (TIMEOUT_CNT - 16'd1)) begin
            state_r      <= S_DONE;
            done_r       <= 1'b1;
            edge_count_r <= 16'd0;
            period_r     <= 16'd0;
            timeout_r    <= 1'b1;
          end else begin
            state_r <= S_ARM;
          end
        end
        S_GATE: begin
          gcnt_r <= gcnt_r + 16'd1;
          ecnt_r <= ecnt_nxt_s;
          pcap_r <= pcap_nxt_s;
          pcnt_r <= rise_s ? 16'd1 : pcnt_sat_s;
          if (gcnt_r == (GATE_CNT - 16'd1)) begin
            state_r      <= S_DONE;
            done_r       <= 1'b1;
            edge_count_r <= ecnt_nxt_s;
            period_r     <= pcap_nxt_s;
            timeout_r    <= 1'b0;
          end else begin
            state_r <= S_GATE;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign edge_count = edge_count_r;
  assign period     = period_r;
  assign timeout    = timeout_r;

endmodule
